reg_file_wb: RTL and testbench
==============================

# reg_file_wb

Architectural register file plus write-back result select for the single-cycle RV32I core. It supplies the `A` and `B` operands to the ALU on read ports 1 and 2. It selects the value to commit from the ALU result, load data or PC+4, and writes it back on the rising clock edge. A registered commit-trace port reports each retired write one cycle later for bench scoreboarding.

## Interface
Parameters:
- `XLEN`, 32: register and datapath width.
- `NREGS`, 32: number of architectural registers; x0 included.

Ports:
- `clk`, in, 1: single clock; all state updates on the rising edge.
- `rst`, in, 1: reset, **synchronous, active-high**.
- `a1`, in, 5: read address, port 1.
- `a2`, in, 5: read address, port 2.
- `a3`, in, 5: write address.
- `we3`, in, 1: write enable.
- `resultsrc`, in, 2: write-back source select.
- `aluresult`, in, XLEN: ALU output.
- `readdata`, in, XLEN: data-memory load data.
- `pcplus4`, in, XLEN: link value.
- `rd1`, out, XLEN: read data, port 1; drives ALU `A`.
- `rd2`, out, XLEN: read data, port 2; drives ALU `B` and store data.
- `result`, out, XLEN: selected write-back value (combinational).
- `wb_valid`, out, 1: a register write committed in the previous cycle.
- `wb_addr`, out, 5: address of that committed write.
- `wb_data`, out, XLEN: data of that committed write.

## Operation
- **Write-back select:** `result` = `aluresult` (00), `readdata` (01), `pcplus4` (10), or 0 (11). Purely combinational.
- **Read:** `rd1` = reg[`a1`] and `rd2` = reg[`a2`], asynchronous.
  - Address 0 always reads 0, independent of storage contents.
- **Write condition:** the write occurs when `we3` && `a3` != 0 && !`rst`. At that rising edge reg[`a3`] <= `result`.
  - Writes to x0 are discarded.
- **Commit trace:** on the same edge as a write, `wb_valid` <= 1, `wb_addr` <= `a3`, `wb_data` <= `result`.
  - Otherwise `wb_valid` <= 0 and `wb_addr`/`wb_data` hold their previous values.
  - A write attempted to x0 does not count as a commit: `wb_valid` <= 0.
- **Read-during-write:** a read of an address written in the same cycle returns the OLD value; the new value is visible from the next cycle.
  - There is no internal bypass. A bypass would form a combinational loop through the ALU in the single-cycle datapath.
- **Reset:** while `rst` is high, writes are blocked and the trace registers clear. Register contents follow the Configuration section.

## Timing
- Read latency 0 cycles (combinational from `a1`/`a2`).
- Write latency 1 edge.
- Trace latency 1 edge after the commit edge.
- `result` and the read ports have no clock dependency other than register contents.
- **Reset values:**
  - `wb_valid` = 0, `wb_addr` = 0, `wb_data` = 0.
  - `rd1`/`rd2` read 0 for address 0 always. For other addresses they follow the Configuration section.
  - `result` is combinational, so it has no reset value.
- **Reset mid-operation:** a write presented in the same cycle as `rst` = 1 is dropped; the target keeps its pre-reset value or its cleared value.
- **Deassertion:** the first write is accepted on the first edge after `rst` falls.

## Configuration
- Macro: `RF_RESET_CLEAR_EN`.
- **Defined:** synchronous reset clears registers 1..NREGS-1 to 0. After reset, every read returns 0.
- **Undefined:** reset does not touch the storage, giving smaller area with no reset fan-out. Register contents are preserved across reset.
  - Only x0 reads 0, and the trace registers still clear.

## Structure
- **Shared package `riscv_pkg`:** `XLEN`, `REG_AW` (=5), and the `resultsrc` encodings `RES_ALU`=2'b00, `RES_MEM`=2'b01, `RES_PC4`=2'b10. The decoder and this block share them.
- **Sub-module `wb_result_mux`:** combinational 4:1 selector producing `result`. It is instantiated once.
- Storage is an array in `reg_file_wb`; no memory macro.

## Test plan
- **Reset clear:** enter reset with `RF_RESET_CLEAR_EN` defined after writing x5=0xDEADBEEF.
  - Required: `rst` 1 cycle, then `a1`=5 -> `rd1`=0, and `wb_valid`=0, `wb_addr`=0, `wb_data`=0.
- **Source select:**
  - `we3`=1, `a3`=7, `resultsrc`=00, `aluresult`=0x12345678 -> next cycle `rd2`(`a2`=7)=0x12345678, `wb_valid`=1, `wb_addr`=7, `wb_data`=0x12345678.
  - Repeat with 01 (`readdata`=0xA5A5A5A5) and 10 (`pcplus4`=0x00000104).
  - `resultsrc`=11 -> `result`=0.
- **x0 protection:** `we3`=1, `a3`=0, `result`=0xFFFFFFFF -> `rd1`(`a1`=0)=0 and `wb_valid`=0 next cycle.
- **Read-during-write:** x3=0x11, then same cycle `a1`=3, `a3`=3, `we3`=1, `result`=0x22.
  - `rd1`=0x11 before the edge and 0x22 after it.
- **Reset during write:** `rst`=1 with `we3`=1, `a3`=9, `aluresult`=0x55.
  - Required: x9 unchanged (0 with the macro, prior value without) and `wb_valid`=0.
- **Reset without macro:** `RF_RESET_CLEAR_EN` undefined, write x31=0xCAFEF00D, pulse `rst` -> `rd1`(`a1`=31)=0xCAFEF00D after reset.

Source files
------------

// File: rtl/riscv_pkg.sv
// Definitions shared by the RV32I decoder and the write-back stage:
// datapath width, register address width and the resultsrc encodings.
package riscv_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;

  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;

endpackage

// File: rtl/wb_result_mux.sv
// Write-back source selector: ALU result, load data or PC+4; code 2'b11 yields zero.
module wb_result_mux #(
  parameter int XLEN = riscv_pkg::XLEN
) (
  input  logic [1:0]      resultsrc,
  input  logic [XLEN-1:0] aluresult,
  input  logic [XLEN-1:0] readdata,
  input  logic [XLEN-1:0] pcplus4,
  output logic [XLEN-1:0] result
);
  import riscv_pkg::*;

  always_comb begin
    result = '0;
    case (resultsrc)
      RES_ALU: result = aluresult;
      RES_MEM: result = readdata;
      RES_PC4: result = pcplus4;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/reg_file_wb.sv
// RV32I register file with write-back select and a one-cycle-delayed commit trace.
// Macro RF_RESET_CLEAR_EN: when defined, reset also clears x1..x(NREGS-1).
module reg_file_wb #(
  parameter int XLEN  = riscv_pkg::XLEN,
  parameter int NREGS = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [riscv_pkg::REG_AW-1:0] a1,
  input  logic [riscv_pkg::REG_AW-1:0] a2,
  input  logic [riscv_pkg::REG_AW-1:0] a3,
  input  logic                        we3,
  input  logic [1:0]                  resultsrc,
  input  logic [XLEN-1:0]             aluresult,
  input  logic [XLEN-1:0]             readdata,
  input  logic [XLEN-1:0]             pcplus4,
  output logic [XLEN-1:0]             rd1,
  output logic [XLEN-1:0]             rd2,
  output logic [XLEN-1:0]             result,
  output logic                        wb_valid,
  output logic [riscv_pkg::REG_AW-1:0] wb_addr,
  output logic [XLEN-1:0]             wb_data
);
  import riscv_pkg::*;

  logic [XLEN-1:0]   r_regs [NREGS];
  logic              r_wb_valid;
  logic [REG_AW-1:0] r_wb_addr;
  logic [XLEN-1:0]   r_wb_data;
  logic [XLEN-1:0]   w_result;
  logic              w_write;

  wb_result_mux #(.XLEN(XLEN)) u_mux (
    .resultsrc (resultsrc),
    .aluresult (aluresult),
    .readdata  (readdata),
    .pcplus4   (pcplus4),
    .result    (w_result)
  );

  assign result  = w_result;
  assign w_write = we3 && (a3 != '0);

  // No bypass: a same-cycle write becomes visible only after the edge.
  assign rd1 = (a1 == '0) ? '0 : r_regs[a1];
  assign rd2 = (a2 == '0) ? '0 : r_regs[a2];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wb_valid <= 1'b0;
      r_wb_addr  <= '0;
      r_wb_data  <= '0;
`ifdef RF_RESET_CLEAR_EN
      for (int i = 1; i < NREGS; i++) r_regs[i] <= '0;
`endif
    end else begin
      r_wb_valid <= w_write;
      if (w_write) begin
        r_regs[a3] <= w_result;
        r_wb_addr  <= a3;
        r_wb_data  <= w_result;
      end
    end
  end

  assign wb_valid = r_wb_valid;
  assign wb_addr  = r_wb_addr;
  assign wb_data  = r_wb_data;

endmodule

// File: tb/tb_reg_file_wb.sv
// Self-checking bench for reg_file_wb; works with or without RF_RESET_CLEAR_EN.
module tb_reg_file_wb;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  a1, a2, a3;
  logic        we3;
  logic [1:0]  resultsrc;
  logic [31:0] aluresult, readdata, pcplus4;
  logic [31:0] rd1, rd2, result;
  logic        wb_valid;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;

  int n_checks = 0;
  int n_errors = 0;

  // Reference state: register contents, which entries hold a known value, trace registers.
  logic [31:0] m_regs  [32];
  logic        m_known [32];
  logic        m_valid;
  logic [4:0]  m_addr;
  logic [31:0] m_data;
  logic [37:0] exp_q [$];

  typedef struct {
    logic [4:0]  wa;
    logic [1:0]  src;
    logic [31:0] alu;
    logic [31:0] rdd;
    logic [31:0] pc4;
    logic [31:0] exp_res;
  } vec_t;
  vec_t vecs [8];

  always #5 clk = ~clk;

  reg_file_wb dut (
    .clk(clk), .rst(rst), .a1(a1), .a2(a2), .a3(a3), .we3(we3),
    .resultsrc(resultsrc), .aluresult(aluresult), .readdata(readdata),
    .pcplus4(pcplus4), .rd1(rd1), .rd2(rd2), .result(result),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic check_rd(input string name, input logic [4:0] addr, input logic [31:0] act);
    if (addr == 5'd0) check(name, act, 32'h0);
    else if (m_known[addr]) check(name, act, m_regs[addr]);
  endtask

  // One clock: drive inputs, check combinational outputs against the old state,
  // update the model, push the expected trace, clock, then pop and compare.
  task automatic step(input logic r, input logic we, input logic [4:0] wa,
                      input logic [1:0] src, input logic [31:0] alu,
                      input logic [31:0] rdd, input logic [31:0] pc4,
                      input logic [31:0] exp_res);
    logic [37:0] e;
    rst = r; we3 = we; a3 = wa; resultsrc = src;
    aluresult = alu; readdata = rdd; pcplus4 = pc4;
    #1;
    check("result", result, exp_res);
    check_rd("rd1_pre_edge", a1, rd1);
    if (r) begin
      m_valid = 1'b0; m_addr = '0; m_data = '0;
`ifdef RF_RESET_CLEAR_EN
      for (int i = 1; i < 32; i++) begin m_regs[i] = '0; m_known[i] = 1'b1; end
`endif
    end else if (we && wa != 5'd0) begin
      m_valid = 1'b1; m_addr = wa; m_data = exp_res;
      m_regs[wa] = exp_res; m_known[wa] = 1'b1;
    end else begin
      m_valid = 1'b0;
    end
    exp_q.push_back({m_valid, m_addr, m_data});
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check("wb_valid", {31'b0, wb_valid}, {31'b0, e[37]});
    check("wb_addr", {27'b0, wb_addr}, {27'b0, e[36:32]});
    check("wb_data", wb_data, e[31:0]);
  endtask

  initial begin
    logic [31:0] rv;
    for (int i = 0; i < 32; i++) begin m_regs[i] = '0; m_known[i] = 1'b0; end
    m_known[0] = 1'b1;
    m_valid = 1'b0; m_addr = '0; m_data = '0;
    rst = 1'b1; we3 = 1'b0; a1 = '0; a2 = '0; a3 = '0; resultsrc = 2'b00;
    aluresult = '0; readdata = '0; pcplus4 = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("reset_wb_valid", {31'b0, wb_valid}, 32'h0);
    check("reset_wb_addr", {27'b0, wb_addr}, 32'h0);
    check("reset_wb_data", wb_data, 32'h0);
    check("reset_rd1_x0", rd1, 32'h0);
    step(1'b1, 1'b0, 5'd0, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0);

    // Source-select table, including the zero code, an x0 write and random vectors
    vecs[0] = '{5'd7,  2'b00, 32'h12345678, 32'h0,        32'h0,        32'h12345678};
    vecs[1] = '{5'd7,  2'b01, 32'h0,        32'hA5A5A5A5, 32'h0,        32'hA5A5A5A5};
    vecs[2] = '{5'd7,  2'b10, 32'h0,        32'h0,        32'h00000104, 32'h00000104};
    vecs[3] = '{5'd8,  2'b11, 32'h1111,     32'h2222,     32'h3333,     32'h0};
    vecs[4] = '{5'd0,  2'b00, 32'hFFFFFFFF, 32'h0,        32'h0,        32'hFFFFFFFF};
    vecs[5] = '{5'd31, 2'b10, 32'h1,        32'h2,        32'h0000BEE4, 32'h0000BEE4};
    for (int i = 6; i < 8; i++) begin
      rv = $urandom;
      vecs[i] = '{5'($urandom_range(1, 30)), 2'b01, ~rv, rv, 32'h0, rv};
    end
    for (int i = 0; i < 8; i++) begin
      a1 = 5'd0;
      a2 = vecs[i].wa;
      step(1'b0, 1'b1, vecs[i].wa, vecs[i].src, vecs[i].alu, vecs[i].rdd,
           vecs[i].pc4, vecs[i].exp_res);
      check_rd("rd2_after_write", a2, rd2);
      check_rd("rd1_x0", a1, rd1);
    end

    // Read-during-write returns the old value until the edge
    a1 = 5'd3;
    step(1'b0, 1'b1, 5'd3, 2'b00, 32'h11, 32'h0, 32'h0, 32'h11);
    check("rdw_before", rd1, 32'h11);
    step(1'b0, 1'b1, 5'd3, 2'b00, 32'h22, 32'h0, 32'h0, 32'h22);
    check("rdw_after", rd1, 32'h22);

    // Reset during a write drops the write
    a1 = 5'd9;
    step(1'b0, 1'b1, 5'd9, 2'b00, 32'h77, 32'h0, 32'h0, 32'h77);
    step(1'b1, 1'b1, 5'd9, 2'b00, 32'h55, 32'h0, 32'h0, 32'h55);
`ifdef RF_RESET_CLEAR_EN
    check("rst_write_x9", rd1, 32'h0);
`else
    check("rst_write_x9", rd1, 32'h77);
`endif

    // First write after reset falls is accepted
    a1 = 5'd12;
    step(1'b0, 1'b1, 5'd12, 2'b01, 32'h0, 32'h600DF00D, 32'h0, 32'h600DF00D);
    check("deassert_first_write", rd1, 32'h600DF00D);

    // Reset clears or preserves storage depending on the build
    step(1'b0, 1'b1, 5'd5, 2'b00, 32'hDEADBEEF, 32'h0, 32'h0, 32'hDEADBEEF);
    step(1'b0, 1'b1, 5'd31, 2'b00, 32'hCAFEF00D, 32'h0, 32'h0, 32'hCAFEF00D);
    step(1'b1, 1'b0, 5'd0, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0);
    a1 = 5'd5; a2 = 5'd31;
    step(1'b0, 1'b0, 5'd0, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0);
`ifdef RF_RESET_CLEAR_EN
    check("reset_clear_x5", rd1, 32'h0);
    check("reset_clear_x31", rd2, 32'h0);
`else
    check("reset_keep_x5", rd1, 32'hDEADBEEF);
    check("reset_keep_x31", rd2, 32'hCAFEF00D);
`endif

    // Random write/read traffic against the model
    for (int i = 0; i < 20; i++) begin
      logic [4:0]  wa;
      logic [1:0]  src;
      logic [31:0] va, vb, vc, ex;
      wa  = 5'($urandom_range(0, 31));
      src = 2'($urandom_range(0, 3));
      va = $urandom; vb = $urandom; vc = $urandom;
      ex = (src == 2'b00) ? va : (src == 2'b01) ? vb : (src == 2'b10) ? vc : 32'h0;
      a1 = 5'($urandom_range(0, 31));
      a2 = wa;
      step(1'b0, 1'($urandom_range(0, 1)), wa, src, va, vb, vc, ex);
      check_rd("rand_rd2", a2, rd2);
    end

    if (exp_q.size() != 0) check("queue_drained", exp_q.size(), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
